bus_dma_arbiter: RTL and testbench
==================================

// Module: bus_dma_arbiter
// PURPOSE
//  Registered arbiter/scheduler for the shared RAM port between the CPU and up to
//  NREQ DMA-capable I/O devices (RK, IDE, ...). Grants DMA only when the CPU signals
//  a safe point, runs bounded round-robin bursts, then guarantees the CPU a refill gap.
//  Drives the RAM-side address/data/strobe mux from the registered grant.
// PARAMETERS
//  NREQ     2   number of DMA requesters (1..4); requester index width fixed at 2 bits
//  BURST    4   max consecutive DMA ack cycles per grant (1..15)
//  CPU_GAP  2   cycles CPU owns the bus after a burst before next DMA grant (0..15)
// PORTS
//  clk            in   1        system clock
//  reset          in   1        asynchronous, active-low reset
//  cpu_arbitrate  in   1        CPU at a point where it may yield the bus
//  cpu_addr       in   22       CPU physical address
//  cpu_data       in   16       CPU write data
//  cpu_rd/cpu_wr  in   1 each   CPU RAM strobes (already qualified by ram_access)
//  cpu_byte_op    in   1        CPU byte operation
//  dma_req        in   NREQ     per-device DMA request, held until done
//  dma_addr       in   NREQ*18  per-device 18-bit address, device i at [18i+17:18i]
//  dma_data       in   NREQ*16  per-device write data, device i at [16i+15:16i]
//  dma_rd/dma_wr  in   NREQ     per-device RAM strobes
//  cpu_ack        out  1        CPU owns RAM port
//  dma_ack        out  NREQ     one-hot DMA ownership
//  dma_owner      out  2        index of current/last DMA owner
//  ram_addr       out  22       muxed RAM address
//  ram_data_out   out  16       muxed RAM write data
//  ram_rd/ram_wr  out  1 each   muxed, owner-gated RAM strobes
//  ram_byte_op    out  1        cpu_byte_op when CPU owns, else 0
//  arb_error      out  1        registered pulse: CPU strobe while cpu_ack=0
// BEHAVIOUR
//  Reset (reset=0, async): state CPU, cpu_ack=1, dma_ack=0, dma_owner=NREQ-1,
//   burst_cnt=0, gap_cnt=0, arb_error=0. Takes effect immediately, even mid-burst.
//  States: CPU, DMA, GAP; all outputs except the mux are registered.
//  CPU: if cpu_arbitrate && |dma_req: winner = first requesting index scanning
//   dma_owner+1, +2, ... mod NREQ; next state DMA, dma_owner=winner,
//   burst_cnt=BURST-1. Latency: ack asserted the cycle after the sampling edge.
//   dma_req without cpu_arbitrate: stay CPU indefinitely.
//  DMA: cpu_ack=0, dma_ack[dma_owner]=1. Each edge: if dma_req[owner]=0 or
//   burst_cnt==0 -> GAP (gap_cnt=CPU_GAP-1) if CPU_GAP>0, else CPU; else burst_cnt--.
//   Full burst => exactly BURST ack cycles. Other requesters' dma_req ignored.
//  GAP: cpu_ack=1, dma_ack=0, dma_req ignored; gap_cnt==0 -> CPU, else gap_cnt--.
//  Mux (combinational from registered state): cpu_ack=1 -> ram_addr=cpu_addr,
//   ram_data_out=cpu_data, ram_rd=cpu_rd, ram_wr=cpu_wr, ram_byte_op=cpu_byte_op.
//   DMA -> ram_addr={4'b0,dma_addr[owner]}, data/strobes of owner only, byte_op=0.
//  cpu_rd|cpu_wr while cpu_ack=0: not forwarded to RAM; arb_error=1 next cycle.
//  Non-owner dma_rd/dma_wr never reach RAM. dma_owner holds after burst (RR pointer).
//  Counters saturate by construction; no wrap beyond the states above.
// TESTING
//  1 reset released, dma_req=0, cpu_rd @22'o001000 -> cpu_ack=1, ram_rd=1, ram_addr=001000.
//  2 dma_req=01, cpu_arbitrate=1 one cycle -> next cycle dma_ack=01 for 4 cycles,
//    then cpu_ack=1 for >=2 cycles; ram_addr={4'b0,dma_addr0}, ram_byte_op=0.
//  3 dma_req=11 held, cpu_arbitrate=1 -> grants alternate dev0,dev1,dev0 with 2-cycle
//    CPU gaps between bursts of 4.
//  4 dev0 drops dma_req after 2 ack cycles -> dma_ack=0 the following cycle, GAP entered.
//  5 cpu_wr=1 during DMA burst -> ram_wr follows DMA only, arb_error pulses 1 cycle.
//  6 reset asserted in 3rd burst cycle -> cpu_ack=1, dma_ack=0 without waiting for clk.

Source files
------------

// File: rtl/bus_dma_arbiter_if.sv
// Shared RAM port bundle between CPU, DMA requesters and the arbiter.
// The arbiter takes the master modport; requesters and the CPU use slave.
interface bus_dma_arbiter_if #(
  parameter int NREQ = 2
);
  logic                 cpu_arbitrate;
  logic [21:0]          cpu_addr;
  logic [15:0]          cpu_data;
  logic                 cpu_rd;
  logic                 cpu_wr;
  logic                 cpu_byte_op;
  logic [NREQ-1:0]      dma_req;
  logic [NREQ*18-1:0]   dma_addr;
  logic [NREQ*16-1:0]   dma_data;
  logic [NREQ-1:0]      dma_rd;
  logic [NREQ-1:0]      dma_wr;
  logic                 cpu_ack;
  logic [NREQ-1:0]      dma_ack;
  logic [1:0]           dma_owner;
  logic [21:0]          ram_addr;
  logic [15:0]          ram_data_out;
  logic                 ram_rd;
  logic                 ram_wr;
  logic                 ram_byte_op;
  logic                 arb_error;

  modport master (
    input  cpu_arbitrate, cpu_addr, cpu_data,
    input  cpu_rd, cpu_wr, cpu_byte_op,
    input  dma_req, dma_addr, dma_data,
    input  dma_rd, dma_wr,
    output cpu_ack, dma_ack, dma_owner,
    output ram_addr, ram_data_out,
    output ram_rd, ram_wr, ram_byte_op,
    output arb_error
  );

  modport slave (
    output cpu_arbitrate, cpu_addr, cpu_data,
    output cpu_rd, cpu_wr, cpu_byte_op,
    output dma_req, dma_addr, dma_data,
    output dma_rd, dma_wr,
    input  cpu_ack, dma_ack, dma_owner,
    input  ram_addr, ram_data_out,
    input  ram_rd, ram_wr, ram_byte_op,
    input  arb_error
  );
endinterface

// File: rtl/bus_dma_arbiter.sv
// CPU/DMA arbiter for the shared RAM port: safe-point grants,
// bounded round-robin bursts, guaranteed CPU refill gap.
module bus_dma_arbiter #(
  parameter int NREQ    = 2,
  parameter int BURST   = 4,
  parameter int CPU_GAP = 2
) (
  input  logic clk,
  input  logic reset,
  bus_dma_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_CPU,
    S_DMA,
    S_GAP
  } state_e;

  localparam logic [1:0] OWNER_RST  = 2'(NREQ - 1);
  localparam logic [3:0] BURST_INIT = 4'(BURST - 1);
  localparam logic [3:0] GAP_INIT   = 4'(CPU_GAP - 1);

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [3:0]      burst_q, burst_d;
  logic [3:0]      gap_q, gap_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic [NREQ-1:0] dma_ack_q, dma_ack_d;
  logic            err_q, err_d;

  // Requester views padded to 4 so a 2-bit owner indexes cleanly.
  logic [3:0]  req4;
  logic [3:0]  rd4;
  logic [3:0]  wr4;
  logic [17:0] addr_a [4];
  logic [15:0] data_a [4];

  for (genvar g = 0; g < 4; g++) begin : g_dev
    if (g < NREQ) begin : g_on
      assign req4[g]   = bus.dma_req[g];
      assign rd4[g]    = bus.dma_rd[g];
      assign wr4[g]    = bus.dma_wr[g];
      assign addr_a[g] = bus.dma_addr[g*18 +: 18];
      assign data_a[g] = bus.dma_data[g*16 +: 16];
    end else begin : g_off
      assign req4[g]   = 1'b0;
      assign rd4[g]    = 1'b0;
      assign wr4[g]    = 1'b0;
      assign addr_a[g] = '0;
      assign data_a[g] = '0;
    end
  end

  logic [1:0] win;
  logic       win_ok;
  logic [1:0] idx;
  int         tmp;

  // Round-robin: scan starting just after the last owner.
  always_comb begin
    win    = owner_q;
    win_ok = 1'b0;
    idx    = '0;
    tmp    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      tmp = (int'(owner_q) + k) % NREQ;
      idx = 2'(tmp);
      if (!win_ok && req4[idx]) begin
        win    = idx;
        win_ok = 1'b1;
      end
    end
  end

  logic [3:0] onehot;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    onehot  = '0;
    unique case (state_q)
      S_CPU: begin
        if (bus.cpu_arbitrate && win_ok) begin
          state_d = S_DMA;
          owner_d = win;
          burst_d = BURST_INIT;
        end
      end
      S_DMA: begin
        if (!req4[owner_q] || burst_q == '0) begin
          if (CPU_GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_INIT;
          end else begin
            state_d = S_CPU;
          end
        end else begin
          burst_d = burst_q - 4'd1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_CPU;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = S_CPU;
    endcase
    cpu_ack_d = (state_d != S_DMA);
    onehot    = 4'b0001 << owner_d;
    dma_ack_d = (state_d == S_DMA) ? onehot[NREQ-1:0] : '0;
    err_d     = (bus.cpu_rd | bus.cpu_wr) & ~cpu_ack_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_CPU;
      owner_q   <= OWNER_RST;
      burst_q   <= '0;
      gap_q     <= '0;
      cpu_ack_q <= 1'b1;
      dma_ack_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      gap_q     <= gap_d;
      cpu_ack_q <= cpu_ack_d;
      dma_ack_q <= dma_ack_d;
      err_q     <= err_d;
    end
  end

  // RAM mux follows registered ownership; CPU strobes are dropped in DMA.
  always_comb begin
    if (cpu_ack_q) begin
      bus.ram_addr     = bus.cpu_addr;
      bus.ram_data_out = bus.cpu_data;
      bus.ram_rd       = bus.cpu_rd;
      bus.ram_wr       = bus.cpu_wr;
      bus.ram_byte_op  = bus.cpu_byte_op;
    end else begin
      bus.ram_addr     = {4'b0000, addr_a[owner_q]};
      bus.ram_data_out = data_a[owner_q];
      bus.ram_rd       = rd4[owner_q];
      bus.ram_wr       = wr4[owner_q];
      bus.ram_byte_op  = 1'b0;
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.dma_owner = owner_q;
  assign bus.arb_error = err_q;

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Directed bench for bus_dma_arbiter: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares.
module tb_bus_dma_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_dma_arbiter_if #(.NREQ(2)) bus ();

  bus_dma_arbiter #(
    .NREQ(2),
    .BURST(4),
    .CPU_GAP(2)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.master)
  );

  localparam logic [21:0] CADDR = 22'o001000;
  localparam logic [15:0] CDATA = 16'hC0DE;
  logic [17:0] daddr [2];
  logic [15:0] ddata [2];
  logic [1:0]  drd;
  logic [1:0]  dwr;

  typedef struct {
    int          tag;
    logic        cack;
    logic [1:0]  dack;
    logic [1:0]  own;
    logic [21:0] addr;
    logic [15:0] data;
    logic        rd;
    logic        wr;
    logic        bop;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cyc(
    input int         tag,
    input logic       arb,
    input logic [1:0] req,
    input logic       crd,
    input logic       cwr,
    input logic       rst_mid,
    input logic       ecack,
    input logic [1:0] edack,
    input logic [1:0] eown,
    input logic       eerr
  );
    exp_t e;
    @(posedge clk);
    #1;
    bus.cpu_arbitrate = arb;
    bus.dma_req       = req;
    bus.cpu_rd        = crd;
    bus.cpu_wr        = cwr;
    if (rst_mid) begin
      #1 rst_n = 1'b0;
    end
    e.tag  = tag;
    e.cack = ecack;
    e.dack = edack;
    e.own  = eown;
    e.addr = ecack ? CADDR : {4'b0000, daddr[eown[0]]};
    e.data = ecack ? CDATA : ddata[eown[0]];
    e.rd   = ecack ? crd : drd[eown[0]];
    e.wr   = ecack ? cwr : dwr[eown[0]];
    e.bop  = ecack;
    e.err  = eerr;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        me = q.pop_front();
        n_cmp++;
        if ({bus.cpu_ack, bus.dma_ack, bus.dma_owner, bus.ram_addr,
             bus.ram_data_out, bus.ram_rd, bus.ram_wr,
             bus.ram_byte_op, bus.arb_error} !==
            {me.cack, me.dack, me.own, me.addr, me.data,
             me.rd, me.wr, me.bop, me.err}) begin
          n_bad++;
          $display("FAIL step%0d: got cack=%b dack=%b own=%0d addr=%o data=%h rd=%b wr=%b bop=%b err=%b; need cack=%b dack=%b own=%0d addr=%o data=%h rd=%b wr=%b bop=%b err=%b",
            me.tag, bus.cpu_ack, bus.dma_ack, bus.dma_owner,
            bus.ram_addr, bus.ram_data_out, bus.ram_rd,
            bus.ram_wr, bus.ram_byte_op, bus.arb_error,
            me.cack, me.dack, me.own, me.addr, me.data,
            me.rd, me.wr, me.bop, me.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench did not finish");
  end

  initial begin
    daddr[0] = 18'h10A0A;
    daddr[1] = 18'h20B0B;
    ddata[0] = 16'hD000;
    ddata[1] = 16'hD111;
    drd = 2'b01;
    dwr = 2'b10;
    bus.cpu_arbitrate = 1'b0;
    bus.cpu_addr      = CADDR;
    bus.cpu_data      = CDATA;
    bus.cpu_rd        = 1'b0;
    bus.cpu_wr        = 1'b0;
    bus.cpu_byte_op   = 1'b1;
    bus.dma_req       = 2'b00;
    bus.dma_addr      = {daddr[1], daddr[0]};
    bus.dma_data      = {ddata[1], ddata[0]};
    bus.dma_rd        = drd;
    bus.dma_wr        = dwr;

    // reset state
    cyc(0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // CPU read, no DMA
    cyc(1, 0, 2'b00, 1, 0, 0, 1, 2'b00, 2'd1, 0);
    cyc(2, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd1, 0);

    // single burst from dev0, then gap
    cyc(3, 1, 2'b01, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    for (int t = 4; t <= 7; t++)
      cyc(t, 0, 2'b01, 0, 0, 0, 0, 2'b01, 2'd0, 0);
    cyc(8, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(9, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(10, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd0, 0);

    // both requesting: alternate dev1, dev0, dev1
    cyc(11, 1, 2'b11, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    for (int t = 12; t <= 15; t++)
      cyc(t, 1, 2'b11, 0, 0, 0, 0, 2'b10, 2'd1, 0);
    cyc(16, 1, 2'b11, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    cyc(17, 1, 2'b11, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    cyc(18, 1, 2'b11, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    for (int t = 19; t <= 22; t++)
      cyc(t, 1, 2'b11, 0, 0, 0, 0, 2'b01, 2'd0, 0);
    cyc(23, 1, 2'b11, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(24, 1, 2'b11, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(25, 1, 2'b11, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    for (int t = 26; t <= 28; t++)
      cyc(t, 1, 2'b11, 0, 0, 0, 0, 2'b10, 2'd1, 0);
    cyc(29, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'd1, 0);
    cyc(30, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    cyc(31, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    cyc(32, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd1, 0);

    // dev0 drops request after two ack cycles
    cyc(33, 1, 2'b01, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    cyc(34, 0, 2'b01, 0, 0, 0, 0, 2'b01, 2'd0, 0);
    cyc(35, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'd0, 0);
    cyc(36, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(37, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(38, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd0, 0);

    // CPU write during burst: blocked, error pulse
    cyc(39, 1, 2'b01, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(40, 0, 2'b01, 0, 1, 0, 0, 2'b01, 2'd0, 0);
    cyc(41, 0, 2'b01, 0, 0, 0, 0, 2'b01, 2'd0, 1);
    cyc(42, 0, 2'b01, 0, 0, 0, 0, 2'b01, 2'd0, 0);
    cyc(43, 0, 2'b01, 0, 0, 0, 0, 2'b01, 2'd0, 0);
    cyc(44, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(45, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(46, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'd0, 0);

    // async reset in third burst cycle
    cyc(47, 1, 2'b01, 0, 0, 0, 1, 2'b00, 2'd0, 0);
    cyc(48, 0, 2'b01, 0, 0, 0, 0, 2'b01, 2'd0, 0);
    cyc(49, 0, 2'b01, 0, 0, 0, 0, 2'b01, 2'd0, 0);
    cyc(50, 0, 2'b01, 0, 0, 1, 1, 2'b00, 2'd1, 0);
    cyc(51, 0, 2'b01, 0, 0, 0, 1, 2'b00, 2'd1, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(52, 0, 2'b00, 1, 0, 0, 1, 2'b00, 2'd1, 0);

    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, need 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
